// File: rtl/w0rm_core_regfile_sb.sv
// W0RM register-fetch stage: multi-port register file with two write-back ports,
// write-before-read bypass, and a per-register scoreboard that stalls decode on RAW/WAW hazards.
module w0rm_core_regfile_sb #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REGISTERS  = 16,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned NUM_USER_BITS  = 64,
  parameter int unsigned ZERO_REG       = 0,
  localparam int unsigned RA = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 decode_valid,
  output logic                                 decode_ready,
  input  logic [NUM_READ_PORTS*RA-1:0]         decode_read_addr,
  input  logic [NUM_READ_PORTS-1:0]            decode_read_used,
  input  logic                                 decode_dest_valid,
  input  logic [RA-1:0]                        decode_dest_addr,
  input  logic [NUM_USER_BITS-1:0]             user_data_in,
  output logic                                 rfetch_valid,
  input  logic                                 rfetch_ready,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rfetch_data,
  output logic [NUM_USER_BITS-1:0]             user_data_out,
  input  logic                                 wb0_enable,
  input  logic [RA-1:0]                        wb0_addr,
  input  logic [DATA_WIDTH-1:0]                wb0_data,
  input  logic                                 wb1_enable,
  input  logic [RA-1:0]                        wb1_addr,
  input  logic [DATA_WIDTH-1:0]                wb1_data,
  output logic [NUM_REGISTERS-1:0]             busy_mask
);

  logic [DATA_WIDTH-1:0]                regs_q [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0]             busy_d;
  logic [RA-1:0]                        src_addr [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0]            src_hazard;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] src_operand;
  logic                                 dest_zero;
  logic                                 dest_hazard;
  logic                                 hazard;
  logic                                 accept;
  logic                                 wb0_write;
  logic                                 wb1_write;

  // Writes to r0 are discarded when r0 is hardwired to zero.
  assign wb0_write = wb0_enable && !((ZERO_REG != 0) && (wb0_addr == '0));
  assign wb1_write = wb1_enable && !((ZERO_REG != 0) && (wb1_addr == '0));

  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_src
    logic hit0;
    logic hit1;
    logic is_zero;
    assign src_addr[k] = decode_read_addr[k*RA +: RA];
    assign hit0        = wb0_enable && (wb0_addr == src_addr[k]);
    assign hit1        = wb1_enable && (wb1_addr == src_addr[k]);
    assign is_zero     = (ZERO_REG != 0) && (src_addr[k] == '0);
    // A write-back landing this cycle resolves the dependency, so it is not a hazard.
    assign src_hazard[k] = decode_read_used[k] && busy_mask[src_addr[k]] && !hit0 && !hit1 &&
                           !is_zero;
    assign src_operand[k*DATA_WIDTH +: DATA_WIDTH] =
        is_zero ? '0 :
        hit0    ? wb0_data :
        hit1    ? wb1_data :
                  regs_q[src_addr[k]];
  end

  assign dest_zero   = (ZERO_REG != 0) && (decode_dest_addr == '0);
  assign dest_hazard = decode_dest_valid && busy_mask[decode_dest_addr] && !dest_zero &&
                       !(wb0_enable && (wb0_addr == decode_dest_addr)) &&
                       !(wb1_enable && (wb1_addr == decode_dest_addr));
  assign hazard       = (|src_hazard) || dest_hazard;
  assign decode_ready = !hazard && (!rfetch_valid || rfetch_ready);
  assign accept       = decode_valid && decode_ready;

  // Scoreboard next state: write-backs clear, a new destination sets (set applied last, so it wins).
  always_comb begin
    busy_d = busy_mask;
    if (wb1_enable) busy_d[wb1_addr] = 1'b0;
    if (wb0_enable) busy_d[wb0_addr] = 1'b0;
    if (accept && decode_dest_valid && !dest_zero) busy_d[decode_dest_addr] = 1'b1;
  end

  // Register file storage; wb0 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < int'(NUM_REGISTERS); r++) regs_q[r] <= '0;
    end else begin
      if (wb1_write) regs_q[wb1_addr] <= wb1_data;
      if (wb0_write) regs_q[wb0_addr] <= wb0_data;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy_mask <= '0;
    else       busy_mask <= busy_d;
  end

  // Output stage: load on accept, hold while stalled, drain when consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rfetch_valid  <= 1'b0;
      rfetch_data   <= '0;
      user_data_out <= '0;
    end else if (accept) begin
      rfetch_valid  <= 1'b1;
      rfetch_data   <= src_operand;
      user_data_out <= user_data_in;
    end else if (rfetch_ready) begin
      rfetch_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w0rm_core_regfile_sb.sv
// Directed self-checking bench for w0rm_core_regfile_sb; a second instance with ZERO_REG=1
// shares the stimulus so hardwired-r0 behaviour can be contrasted with the default.
module tb_w0rm_core_regfile_sb;

  logic        clk;
  logic        reset;
  logic        decode_valid;
  logic [7:0]  decode_read_addr;
  logic [1:0]  decode_read_used;
  logic        decode_dest_valid;
  logic [3:0]  decode_dest_addr;
  logic [63:0] user_data_in;
  logic        rfetch_ready;
  logic        wb0_enable;
  logic [3:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb1_enable;
  logic [3:0]  wb1_addr;
  logic [31:0] wb1_data;

  logic        decode_ready,  z_decode_ready;
  logic        rfetch_valid,  z_rfetch_valid;
  logic [63:0] rfetch_data,   z_rfetch_data;
  logic [63:0] user_data_out, z_user_data_out;
  logic [15:0] busy_mask,     z_busy_mask;

  int vectors = 0;
  int miscompares = 0;

  w0rm_core_regfile_sb dut (
    .clk(clk), .reset(reset),
    .decode_valid(decode_valid), .decode_ready(decode_ready),
    .decode_read_addr(decode_read_addr), .decode_read_used(decode_read_used),
    .decode_dest_valid(decode_dest_valid), .decode_dest_addr(decode_dest_addr),
    .user_data_in(user_data_in),
    .rfetch_valid(rfetch_valid), .rfetch_ready(rfetch_ready),
    .rfetch_data(rfetch_data), .user_data_out(user_data_out),
    .wb0_enable(wb0_enable), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_enable(wb1_enable), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .busy_mask(busy_mask)
  );

  w0rm_core_regfile_sb #(.ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset),
    .decode_valid(decode_valid), .decode_ready(z_decode_ready),
    .decode_read_addr(decode_read_addr), .decode_read_used(decode_read_used),
    .decode_dest_valid(decode_dest_valid), .decode_dest_addr(decode_dest_addr),
    .user_data_in(user_data_in),
    .rfetch_valid(z_rfetch_valid), .rfetch_ready(rfetch_ready),
    .rfetch_data(z_rfetch_data), .user_data_out(z_user_data_out),
    .wb0_enable(wb0_enable), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_enable(wb1_enable), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .busy_mask(z_busy_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, want finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    decode_valid      = 1'b0;
    decode_read_addr  = '0;
    decode_read_used  = '0;
    decode_dest_valid = 1'b0;
    decode_dest_addr  = '0;
    user_data_in      = '0;
    rfetch_ready      = 1'b1;
    wb0_enable        = 1'b0;
    wb0_addr          = '0;
    wb0_data          = '0;
    wb1_enable        = 1'b0;
    wb1_addr          = '0;
    wb1_data          = '0;
  endtask

  // Present an instruction: port1 addr p1, port0 addr p0.
  task automatic issue(input logic [3:0] p1, input logic [3:0] p0, input logic [1:0] used,
                       input logic dv, input logic [3:0] dest, input logic [63:0] user);
    decode_valid      = 1'b1;
    decode_read_addr  = {p1, p0};
    decode_read_used  = used;
    decode_dest_valid = dv;
    decode_dest_addr  = dest;
    user_data_in      = user;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (busy_mask !== 16'h0) begin
      miscompares++; $display("FAIL reset_busy: got %h want 0000", busy_mask);
    end
    vectors++;
    if (rfetch_valid !== 1'b0 || rfetch_data !== 64'h0 || user_data_out !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_out: got v=%b d=%h u=%h want 0/0/0", rfetch_valid, rfetch_data,
               user_data_out);
    end
    vectors++;
    if (decode_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b want 1", decode_ready);
    end
  endtask

  task automatic test_read_after_write();
    wb0_enable = 1'b1; wb0_addr = 4'd3; wb0_data = 32'hDEADBEEF;
    tick();
    clear_inputs();
    issue(4'd0, 4'd3, 2'b11, 1'b0, 4'd0, 64'h1111);
    #1;
    vectors++;
    if (decode_ready !== 1'b1) begin
      miscompares++; $display("FAIL raw_ready: got %b want 1", decode_ready);
    end
    tick();
    clear_inputs();
    vectors++;
    if (rfetch_valid !== 1'b1 || rfetch_data !== 64'h00000000_DEADBEEF ||
        user_data_out !== 64'h1111) begin
      miscompares++;
      $display("FAIL read_r3: got v=%b d=%h u=%h want 1/00000000deadbeef/1111", rfetch_valid,
               rfetch_data, user_data_out);
    end
    tick();
    vectors++;
    if (rfetch_valid !== 1'b0) begin
      miscompares++; $display("FAIL drain_valid: got %b want 0", rfetch_valid);
    end
  endtask

  task automatic test_bypass();
    wb1_enable = 1'b1; wb1_addr = 4'd5; wb1_data = 32'h1234;
    issue(4'd5, 4'd5, 2'b11, 1'b0, 4'd0, 64'h2222);
    tick();
    clear_inputs();
    vectors++;
    if (rfetch_data !== 64'h00001234_00001234) begin
      miscompares++; $display("FAIL bypass_wb1: got %h want 0000123400001234", rfetch_data);
    end
    wb0_enable = 1'b1; wb0_addr = 4'd5; wb0_data = 32'hA;
    wb1_enable = 1'b1; wb1_addr = 4'd5; wb1_data = 32'hB;
    tick();
    clear_inputs();
    issue(4'd3, 4'd5, 2'b11, 1'b0, 4'd0, 64'h3333);
    tick();
    clear_inputs();
    vectors++;
    if (rfetch_data !== 64'hDEADBEEF_0000000A) begin
      miscompares++; $display("FAIL wb_priority: got %h want deadbeef0000000a", rfetch_data);
    end
    tick();
  endtask

  task automatic test_raw_hazard();
    issue(4'd0, 4'd0, 2'b00, 1'b1, 4'd2, 64'h4444);
    tick();
    vectors++;
    if (busy_mask !== 16'h0004) begin
      miscompares++; $display("FAIL busy_set: got %h want 0004", busy_mask);
    end
    issue(4'd0, 4'd2, 2'b01, 1'b0, 4'd0, 64'h5555);
    #1;
    vectors++;
    if (decode_ready !== 1'b0) begin
      miscompares++; $display("FAIL raw_stall0: got %b want 0", decode_ready);
    end
    tick();
    vectors++;
    if (rfetch_valid !== 1'b0 || decode_ready !== 1'b0 || busy_mask !== 16'h0004) begin
      miscompares++;
      $display("FAIL raw_stall1: got v=%b rdy=%b busy=%h want 0/0/0004", rfetch_valid,
               decode_ready, busy_mask);
    end
    wb0_enable = 1'b1; wb0_addr = 4'd2; wb0_data = 32'd7;
    #1;
    vectors++;
    if (decode_ready !== 1'b1) begin
      miscompares++; $display("FAIL raw_release: got %b want 1", decode_ready);
    end
    tick();
    clear_inputs();
    vectors++;
    if (rfetch_valid !== 1'b1 || rfetch_data[31:0] !== 32'd7 || user_data_out !== 64'h5555 ||
        busy_mask !== 16'h0) begin
      miscompares++;
      $display("FAIL raw_bypass: got v=%b op0=%h u=%h busy=%h want 1/00000007/5555/0000",
               rfetch_valid, rfetch_data[31:0], user_data_out, busy_mask);
    end
    // Set and clear of r2 in one cycle: set wins.
    issue(4'd0, 4'd0, 2'b00, 1'b1, 4'd2, 64'h6666);
    tick();
    issue(4'd0, 4'd0, 2'b00, 1'b1, 4'd2, 64'h7777);
    wb0_enable = 1'b1; wb0_addr = 4'd2; wb0_data = 32'd9;
    #1;
    vectors++;
    if (decode_ready !== 1'b1) begin
      miscompares++; $display("FAIL waw_release: got %b want 1", decode_ready);
    end
    tick();
    clear_inputs();
    vectors++;
    if (busy_mask !== 16'h0004 || user_data_out !== 64'h7777) begin
      miscompares++;
      $display("FAIL set_wins: got busy=%h u=%h want 0004/7777", busy_mask, user_data_out);
    end
    wb0_enable = 1'b1; wb0_addr = 4'd2; wb0_data = 32'd9;
    tick();
    clear_inputs();
    vectors++;
    if (busy_mask !== 16'h0) begin
      miscompares++; $display("FAIL busy_clear: got %h want 0000", busy_mask);
    end
  endtask

  task automatic test_back_to_back();
    issue(4'd0, 4'd5, 2'b01, 1'b0, 4'd0, 64'h1);
    tick();
    issue(4'd0, 4'd3, 2'b01, 1'b0, 4'd0, 64'h2);
    #1;
    vectors++;
    if (decode_ready !== 1'b1 || rfetch_data[31:0] !== 32'hA) begin
      miscompares++;
      $display("FAIL b2b_first: got rdy=%b op0=%h want 1/0000000a", decode_ready,
               rfetch_data[31:0]);
    end
    tick();
    clear_inputs();
    vectors++;
    if (rfetch_valid !== 1'b1 || rfetch_data[31:0] !== 32'hDEADBEEF || user_data_out !== 64'h2)
    begin
      miscompares++;
      $display("FAIL b2b_second: got v=%b op0=%h u=%h want 1/deadbeef/2", rfetch_valid,
               rfetch_data[31:0], user_data_out);
    end
    tick();
  endtask

  task automatic test_backpressure();
    issue(4'd0, 4'd3, 2'b01, 1'b0, 4'd0, 64'hAAAA);
    rfetch_ready = 1'b0;
    tick();
    issue(4'd3, 4'd5, 2'b11, 1'b0, 4'd0, 64'hBBBB);
    wb0_enable = 1'b1; wb0_addr = 4'd3; wb0_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (decode_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_ready%0d: got %b want 0", i, decode_ready);
      end
      tick();
      wb0_enable = 1'b0;
      vectors++;
      if (rfetch_valid !== 1'b1 || rfetch_data[31:0] !== 32'hDEADBEEF ||
          user_data_out !== 64'hAAAA) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got v=%b op0=%h u=%h want 1/deadbeef/aaaa", i, rfetch_valid,
                 rfetch_data[31:0], user_data_out);
      end
    end
    rfetch_ready = 1'b1;
    #1;
    vectors++;
    if (decode_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release: got %b want 1", decode_ready);
    end
    tick();
    clear_inputs();
    vectors++;
    if (rfetch_data !== 64'h00000055_0000000A || user_data_out !== 64'hBBBB) begin
      miscompares++;
      $display("FAIL bp_next: got d=%h u=%h want 000000550000000a/bbbb", rfetch_data,
               user_data_out);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    wb0_enable = 1'b1; wb0_addr = 4'd0; wb0_data = 32'hFF;
    tick();
    clear_inputs();
    issue(4'd0, 4'd0, 2'b11, 1'b1, 4'd0, 64'hC);
    #1;
    vectors++;
    if (decode_ready !== 1'b1 || z_decode_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_ready: got %b/%b want 1/1", decode_ready, z_decode_ready);
    end
    tick();
    clear_inputs();
    vectors++;
    if (z_rfetch_data !== 64'h0 || z_busy_mask !== 16'h0) begin
      miscompares++;
      $display("FAIL zero_r0: got d=%h busy=%h want 0/0000", z_rfetch_data, z_busy_mask);
    end
    vectors++;
    if (rfetch_data !== 64'h000000FF_000000FF || busy_mask !== 16'h0001) begin
      miscompares++;
      $display("FAIL plain_r0: got d=%h busy=%h want 000000ff000000ff/0001", rfetch_data,
               busy_mask);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    issue(4'd0, 4'd3, 2'b01, 1'b1, 4'd7, 64'hD);
    rfetch_ready = 1'b0;
    tick();
    clear_inputs();
    rfetch_ready = 1'b0;
    vectors++;
    if (rfetch_valid !== 1'b1 || busy_mask !== 16'h0081) begin
      miscompares++;
      $display("FAIL pre_reset: got v=%b busy=%h want 1/0081", rfetch_valid, busy_mask);
    end
    reset = 1'b1;
    wb0_enable = 1'b1; wb0_addr = 4'd4; wb0_data = 32'h99;
    tick();
    reset = 1'b0;
    clear_inputs();
    vectors++;
    if (rfetch_valid !== 1'b0 || rfetch_data !== 64'h0 || user_data_out !== 64'h0 ||
        busy_mask !== 16'h0) begin
      miscompares++;
      $display("FAIL post_reset: got v=%b d=%h u=%h busy=%h want all 0", rfetch_valid,
               rfetch_data, user_data_out, busy_mask);
    end
    issue(4'd4, 4'd3, 2'b11, 1'b0, 4'd0, 64'hE);
    tick();
    clear_inputs();
    vectors++;
    if (rfetch_valid !== 1'b1 || rfetch_data !== 64'h0) begin
      miscompares++;
      $display("FAIL regs_cleared: got v=%b d=%h want 1/0", rfetch_valid, rfetch_data);
    end
  endtask

  initial begin
    test_reset();
    test_read_after_write();
    test_bypass();
    test_raw_hazard();
    test_back_to_back();
    test_backpressure();
    test_zero_reg();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
